// File: rtl/arith_pkg.sv
// Shared state encoding and default widths for the sample accumulator slice.
// Optional feature macro: ACC_SAT_EN (saturating sum instead of wrapping sum).
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 4;
    localparam int DEF_SUM_W  = 10;

endpackage

// File: rtl/acc_add.sv
// Combinational sum+sample adder with carry-out; saturates at all-ones when
// ACC_SAT_EN is defined, otherwise wraps modulo 2^SUM_W.
module acc_add
    import arith_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SUM_W  = DEF_SUM_W
) (
    input  logic [SUM_W-1:0]  i_sum,
    input  logic [DATA_W-1:0] i_data,
    output logic [SUM_W-1:0]  o_sum,
    output logic              o_ovf
);

    logic [SUM_W:0] w_full;

    assign w_full = {1'b0, i_sum} + (SUM_W+1)'(i_data);
    assign o_ovf  = w_full[SUM_W];

    always_comb begin
        o_sum = w_full[SUM_W-1:0];
`ifdef ACC_SAT_EN
        if (w_full[SUM_W]) begin
            o_sum = '1;
        end
`endif
    end

endmodule

// File: rtl/sample_accumulator.sv
// Block accumulator: sums len samples after a start, pulses done with the final sum.
// Overflow handling selected by ACC_SAT_EN inside acc_add.
module sample_accumulator
    import arith_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int SUM_W  = DEF_SUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SUM_W-1:0]  sum,
    output logic              done,
    output logic              busy,
    output logic              ovf
);

    acc_state_t       r_state;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] r_sum;
    logic             r_ovf;
    logic             r_done;

    logic [SUM_W-1:0] w_sum;
    logic             w_carry;

    acc_add #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_acc_add (
        .i_sum  (r_sum),
        .i_data (in_data),
        .o_sum  (w_sum),
        .o_ovf  (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len <= len;
                        r_cnt <= '0;
                        r_sum <= '0;
                        r_ovf <= 1'b0;
                        if (len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ACC;
                        end
                    end
                end
                ACC: begin
                    // in_ready is 1 throughout ACC, so in_valid alone is the handshake
                    if (in_valid) begin
                        r_sum <= w_sum;
                        r_ovf <= r_ovf | w_carry;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == r_len - CNT_W'(1)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = (r_state == ACC);
    assign busy     = (r_state != IDLE);
    assign sum      = r_sum;
    assign ovf      = r_ovf;
    assign done     = r_done;

endmodule
